// File: rtl/uart_pkg.sv
// UART transmitter shared types and constants.
// Optional parity build: define UART_TX_PARITY_EN.
package uart_pkg;

  typedef logic [2:0] uart_state_t;

  localparam uart_state_t ST_IDLE   = 3'd0;
  localparam uart_state_t ST_ARM    = 3'd1;
  localparam uart_state_t ST_START  = 3'd2;
  localparam uart_state_t ST_DATA   = 3'd3;
  localparam uart_state_t ST_PARITY = 3'd4;
  localparam uart_state_t ST_STOP   = 3'd5;

  localparam int   UART_DATA_BITS  = 8;
  localparam int   UART_STOP_BITS  = 1;
  localparam logic UART_IDLE_LEVEL = 1'b1;

  function automatic logic even_parity(
    input logic [UART_DATA_BITS-1:0] d
  );
    return ^d;
  endfunction

endpackage

// File: rtl/uart_baud_edge.sv
// Baud square-wave synchroniser and rising-edge detector.
// Produces a single clk_in-cycle tick per baud_in rising edge.
module baud_edge (
  input  logic clk_in,
  input  logic reset,
  input  logic baud_in,
  output logic tick
);

  logic s1;
  logic s2;
  logic d;

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      d  <= 1'b0;
    end else begin
      s1 <= baud_in;
      s2 <= s1;
      d  <= s2;
    end
  end

  assign tick = s2 & ~d;

endmodule

// File: rtl/uart_tx.sv
// UART byte transmitter: 8N1 frame, or 8E1 with UART_TX_PARITY_EN.
// Bit timing comes from the baud_in square wave via baud_edge.
import uart_pkg::*;

module uart_tx (
  input  logic       clk_in,
  input  logic       reset,
  input  logic       baud_in,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       txd,
  output logic       busy
);

  localparam logic [2:0] LAST_BIT = 3'(UART_DATA_BITS - 1);

  uart_state_t state;
  logic [7:0]  shreg;
  logic [2:0]  bit_idx;
  logic        tick;

`ifdef UART_TX_PARITY_EN
  logic par_bit;
`endif

  baud_edge u_baud_edge (
    .clk_in  (clk_in),
    .reset   (reset),
    .baud_in (baud_in),
    .tick    (tick)
  );

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      state    <= ST_IDLE;
      shreg    <= '0;
      bit_idx  <= '0;
      txd      <= UART_IDLE_LEVEL;
      tx_ready <= 1'b1;
      busy     <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_bit  <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          txd      <= UART_IDLE_LEVEL;
          tx_ready <= 1'b1;
          busy     <= 1'b0;
          if (tx_valid) begin
            shreg    <= tx_data;
            state    <= ST_ARM;
            tx_ready <= 1'b0;
            busy     <= 1'b1;
`ifdef UART_TX_PARITY_EN
            par_bit  <= even_parity(tx_data);
`endif
          end
        end
        ST_ARM: begin
          if (tick) begin
            state <= ST_START;
            txd   <= 1'b0;
          end
        end
        ST_START: begin
          if (tick) begin
            state   <= ST_DATA;
            txd     <= shreg[0];
            shreg   <= {1'b0, shreg[7:1]};
            bit_idx <= '0;
          end
        end
        ST_DATA: begin
          if (tick) begin
            if (bit_idx == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
              state <= ST_PARITY;
              txd   <= par_bit;
`else
              state <= ST_STOP;
              txd   <= UART_IDLE_LEVEL;
`endif
            end else begin
              txd     <= shreg[0];
              shreg   <= {1'b0, shreg[7:1]};
              bit_idx <= bit_idx + 3'd1;
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        ST_PARITY: begin
          if (tick) begin
            state <= ST_STOP;
            txd   <= UART_IDLE_LEVEL;
          end
        end
`endif
        ST_STOP: begin
          txd <= UART_IDLE_LEVEL;
          if (tick) begin
            state    <= ST_IDLE;
            tx_ready <= 1'b1;
            busy     <= 1'b0;
          end
        end
        default: begin
          state    <= ST_IDLE;
          txd      <= UART_IDLE_LEVEL;
          tx_ready <= 1'b1;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Directed testbench for uart_tx (both parity builds).
// Expected frames are built from the data byte, LSB first.
module tb_uart_tx;

  logic       clk_in;
  logic       reset;
  logic       baud_in;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       txd;
  logic       busy;

  int n_cmp;
  int n_err;

`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif

  uart_tx dut (
    .clk_in   (clk_in),
    .reset    (reset),
    .baud_in  (baud_in),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .txd      (txd),
    .busy     (busy)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  // line level per tick, index 0 = start bit
  function automatic logic [10:0] frame_of(input logic [7:0] d);
    logic [10:0] f;
    f      = '1;
    f[0]   = 1'b0;
    f[8:1] = d;
`ifdef UART_TX_PARITY_EN
    f[9]   = ^d;
    f[10]  = 1'b1;
`else
    f[9]   = 1'b1;
`endif
    return f;
  endfunction

  task automatic do_tick(output logic v);
    @(negedge clk_in) baud_in = 1'b1;
    repeat (3) @(posedge clk_in);
    #1 v = txd;
    @(negedge clk_in) baud_in = 1'b0;
    repeat (3) @(negedge clk_in);
  endtask

  task automatic accept(input logic [7:0] d);
    @(negedge clk_in);
    tx_data  = d;
    tx_valid = 1'b1;
    @(negedge clk_in);
    tx_valid = 1'b0;
    tx_data  = ~d;
  endtask

  task automatic test_reset;
    reset    = 1'b0;
    baud_in  = 1'b0;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    repeat (3) @(negedge clk_in);
    n_cmp++;
    if (txd !== 1'b1) begin
      n_err++;
      $display("FAIL reset_txd got=%b exp=1", txd);
    end
    n_cmp++;
    if (tx_ready !== 1'b1) begin
      n_err++;
      $display("FAIL reset_ready got=%b exp=1", tx_ready);
    end
    n_cmp++;
    if (busy !== 1'b0) begin
      n_err++;
      $display("FAIL reset_busy got=%b exp=0", busy);
    end
    reset = 1'b1;
    repeat (3) @(negedge clk_in);
  endtask

  task automatic test_idle_baud;
    logic v;
    for (int i = 0; i < 5; i++) begin
      do_tick(v);
      n_cmp++;
      if ({v, tx_ready, busy} !== 3'b110) begin
        n_err++;
        $display("FAIL idle_baud[%0d] got txd/rdy/busy=%b%b%b exp=110",
                 i, v, tx_ready, busy);
      end
    end
  endtask

  task automatic test_send(input logic [7:0] d);
    logic [10:0] exp;
    logic        v;
    exp = frame_of(d);
    accept(d);
    n_cmp++;
    if ({txd, tx_ready, busy} !== 3'b101) begin
      n_err++;
      $display("FAIL send_%h_accept got txd/rdy/busy=%b%b%b exp=101",
               d, txd, tx_ready, busy);
    end
    for (int i = 0; i < NB; i++) begin
      do_tick(v);
      n_cmp++;
      if (v !== exp[i]) begin
        n_err++;
        $display("FAIL send_%h_bit[%0d] got=%b exp=%b", d, i, v, exp[i]);
      end
    end
    n_cmp++;
    if (tx_ready !== 1'b0) begin
      n_err++;
      $display("FAIL send_%h_stop_ready got=%b exp=0", d, tx_ready);
    end
    do_tick(v);
    n_cmp++;
    if ({v, tx_ready, busy} !== 3'b110) begin
      n_err++;
      $display("FAIL send_%h_done got txd/rdy/busy=%b%b%b exp=110",
               d, v, tx_ready, busy);
    end
  endtask

  task automatic test_ignore_busy;
    logic [10:0] exp;
    logic        v;
    exp = frame_of(8'hA5);
    accept(8'hA5);
    for (int i = 0; i < NB; i++) begin
      do_tick(v);
      n_cmp++;
      if (v !== exp[i]) begin
        n_err++;
        $display("FAIL ignore_bit[%0d] got=%b exp=%b", i, v, exp[i]);
      end
      if (i == 3) begin
        @(negedge clk_in);
        tx_data  = 8'h3C;
        tx_valid = 1'b1;
        @(negedge clk_in);
        tx_valid = 1'b0;
        n_cmp++;
        if (tx_ready !== 1'b0) begin
          n_err++;
          $display("FAIL ignore_ready got=%b exp=0", tx_ready);
        end
      end
    end
    for (int i = 0; i < 3; i++) begin
      do_tick(v);
      n_cmp++;
      if ({v, busy} !== 2'b10) begin
        n_err++;
        $display("FAIL ignore_after[%0d] got txd/busy=%b%b exp=10",
                 i, v, busy);
      end
    end
  endtask

  task automatic test_reset_midframe;
    logic [10:0] exp;
    logic        v;
    exp = frame_of(8'hA5);
    accept(8'hA5);
    for (int i = 0; i < 5; i++) begin
      do_tick(v);
      n_cmp++;
      if (v !== exp[i]) begin
        n_err++;
        $display("FAIL midrst_bit[%0d] got=%b exp=%b", i, v, exp[i]);
      end
    end
    @(negedge clk_in);
    reset = 1'b0;
    #1;
    n_cmp++;
    if ({txd, tx_ready, busy} !== 3'b110) begin
      n_err++;
      $display("FAIL midrst_async got txd/rdy/busy=%b%b%b exp=110",
               txd, tx_ready, busy);
    end
    repeat (2) @(negedge clk_in);
    reset = 1'b1;
    repeat (2) @(negedge clk_in);
    test_send(8'h55);
  endtask

  task automatic test_stall_arm;
    logic [10:0] exp;
    logic        v;
    exp = frame_of(8'hA5);
    accept(8'hA5);
    repeat (10000) @(posedge clk_in);
    #1;
    n_cmp++;
    if ({txd, tx_ready, busy} !== 3'b101) begin
      n_err++;
      $display("FAIL stall_hold got txd/rdy/busy=%b%b%b exp=101",
               txd, tx_ready, busy);
    end
    @(negedge clk_in) baud_in = 1'b1;
    @(posedge clk_in);
    #1;
    n_cmp++;
    if (txd !== 1'b1) begin
      n_err++;
      $display("FAIL stall_edge1 got=%b exp=1", txd);
    end
    @(posedge clk_in);
    #1;
    n_cmp++;
    if (txd !== 1'b1) begin
      n_err++;
      $display("FAIL stall_edge2 got=%b exp=1", txd);
    end
    @(posedge clk_in);
    #1;
    n_cmp++;
    if (txd !== 1'b0) begin
      n_err++;
      $display("FAIL stall_edge3 got=%b exp=0", txd);
    end
    @(negedge clk_in) baud_in = 1'b0;
    repeat (3) @(negedge clk_in);
    for (int i = 1; i < NB; i++) begin
      do_tick(v);
      n_cmp++;
      if (v !== exp[i]) begin
        n_err++;
        $display("FAIL stall_bit[%0d] got=%b exp=%b", i, v, exp[i]);
      end
    end
    do_tick(v);
    n_cmp++;
    if ({v, tx_ready, busy} !== 3'b110) begin
      n_err++;
      $display("FAIL stall_done got txd/rdy/busy=%b%b%b exp=110",
               v, tx_ready, busy);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    test_reset();
    test_idle_baud();
    test_send(8'hA5);
    test_send(8'h01);
    test_ignore_busy();
    test_reset_midframe();
    test_stall_arm();
    test_send(8'hFF);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
